// File: rtl/cache_bus_pkg.sv
// Shared bus command and arbiter state types for the snooping cache bus.
// Used by the arbiter, the cache controllers and the bench.
package cache_bus_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_WB   = 2'b11
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SNOOP = 2'b01,
    MEM   = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/cache_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester after last_owner wins,
// with last_owner itself taking lowest priority.
module rr_picker #(
  parameter int NUM_CORES = 2,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last_owner,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan from lowest to highest priority so the nearest requester overwrites the rest.
  always_comb begin
    valid  = 1'b0;
    index  = {IDX_W{1'b0}};
    sum_s  = {(IDX_W+1){1'b0}};
    cand_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      sum_s  = {1'b0, last_owner} + (IDX_W+1)'(i);
      cand_s = (sum_s >= (IDX_W+1)'(NUM_CORES)) ? IDX_W'(sum_s - (IDX_W+1)'(NUM_CORES))
                                                : sum_s[IDX_W-1:0];
      hit_s  = req[cand_s];
      valid  = valid | hit_s;
      index  = hit_s ? cand_s : index;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Snooping cache bus arbiter: round-robin grant, one-cycle snoop broadcast,
// optional memory access, then a one-cycle done pulse to the owning core.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CORES-1:0]         req,
  input  logic [NUM_CORES*2-1:0]       cmd,
  input  logic [NUM_CORES*ADDR_W-1:0]  addr,
  input  logic [NUM_CORES*DATA_W-1:0]  wdata,
  output logic [NUM_CORES-1:0]         gnt,
  output logic [NUM_CORES-1:0]         done,
  output logic [DATA_W-1:0]            rdata,
  output logic                         snoop_valid,
  output bus_cmd_t                     snoop_cmd,
  output logic [ADDR_W-1:0]            snoop_addr,
  output logic [$clog2(NUM_CORES)-1:0] snoop_src,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int               IDX_W     = $clog2(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(NUM_CORES - 1);

  arb_state_t        state_r, state_next_s;
  bus_cmd_t          cmd_r, sel_cmd_s;
  logic [ADDR_W-1:0] addr_r, sel_addr_s;
  logic [DATA_W-1:0] wdata_r, sel_wdata_s;
  logic [IDX_W-1:0]  owner_r, last_owner_r, win_idx_s, owner_next_s;
  logic              win_valid_s, start_s;

  function automatic logic [NUM_CORES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CORES-1:0] vec;
    vec      = {NUM_CORES{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_picker (
    .req        (req),
    .last_owner (last_owner_r),
    .valid      (win_valid_s),
    .index      (win_idx_s)
  );

  assign sel_cmd_s    = bus_cmd_t'(cmd[int'(win_idx_s)*CMD_W +: CMD_W]);
  assign sel_addr_s   = addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
  assign sel_wdata_s  = wdata[int'(win_idx_s)*DATA_W +: DATA_W];
  assign start_s      = (state_r == IDLE) && win_valid_s;
  assign owner_next_s = start_s ? win_idx_s : owner_r;

  // Next-state decode; upgrades skip memory since the line is already held.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = win_valid_s ? SNOOP : IDLE;
      SNOOP:   state_next_s = (cmd_r == BUS_UPGR) ? RESP : MEM;
      MEM:     state_next_s = mem_ready ? RESP : MEM;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Transaction latch: the winner's request is frozen until the transaction ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r        <= BUS_RD;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      owner_r      <= {IDX_W{1'b0}};
      last_owner_r <= LAST_CORE;
    end else begin
      if (start_s) begin
        cmd_r   <= sel_cmd_s;
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
        owner_r <= win_idx_s;
      end
      if (state_r == RESP) begin
        last_owner_r <= owner_r;
      end
    end
  end

  // Outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt         <= {NUM_CORES{1'b0}};
      done        <= {NUM_CORES{1'b0}};
      rdata       <= {DATA_W{1'b0}};
      snoop_valid <= 1'b0;
      snoop_cmd   <= BUS_RD;
      snoop_addr  <= {ADDR_W{1'b0}};
      snoop_src   <= {IDX_W{1'b0}};
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
    end else begin
      gnt         <= (state_next_s != IDLE) ? idx_onehot(owner_next_s) : {NUM_CORES{1'b0}};
      done        <= (state_next_s == RESP) ? idx_onehot(owner_next_s) : {NUM_CORES{1'b0}};
      snoop_valid <= (state_next_s == SNOOP);
      mem_req     <= (state_next_s == MEM);
      mem_we      <= (state_next_s == MEM) && (cmd_r == BUS_WB);
      rdata       <= ((state_r == MEM) && (state_next_s == RESP) && (cmd_r != BUS_WB))
                     ? mem_rdata : {DATA_W{1'b0}};
      if (start_s) begin
        snoop_cmd  <= sel_cmd_s;
        snoop_addr <= sel_addr_s;
        snoop_src  <= win_idx_s;
      end
      if ((state_r == SNOOP) && (state_next_s == MEM)) begin
        mem_addr  <= addr_r;
        mem_wdata <= wdata_r;
      end
    end
  end

endmodule
